// File: rtl/decode_pkg.sv
// Shared decode-side types: instruction buffer depth,
// fetch bundle and buffer control states.
package decode_pkg;

  localparam int IBUF_DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ibuf_state_t;

endpackage

// File: rtl/ibuf_ctrl.sv
// Instruction buffer between fetch and decode:
// circular queue with valid/ready on both sides and flush.
module ibuf_ctrl
  import decode_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instr,
  input  logic [31:0]            pc_in,
  input  logic                   valid_in,
  output logic                   ready_in,
  output logic [31:0]            instr_out,
  output logic [31:0]            pc_out,
  output logic                   valid_out,
  input  logic                   ready_out,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  ibuf_state_t   r_state;
  ibuf_state_t   w_state_nxt;
  logic          w_enq;
  logic          w_deq;

  // ready_in depends only on state, occupancy and flush,
  // never on ready_out.
  always_comb begin
    w_state_nxt = r_state;
    ready_in    = 1'b0;
    valid_out   = 1'b0;
    unique case (r_state)
      RUN: begin
        ready_in  = (r_count != FULL) && !flush;
        valid_out = (r_count != '0) && !flush;
        if (flush) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!flush) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_enq     = valid_in && ready_in;
  assign w_deq     = valid_out && ready_out;
  assign instr_out = r_mem[r_head].instr;
  assign pc_out    = r_mem[r_head].pc;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) r_tail <= r_tail + 1'b1;
        if (w_deq) r_head <= r_head + 1'b1;
        unique case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq && !reset)
      r_mem[r_tail] <= '{instr: instr, pc: pc_in};
  end

endmodule
